shift_ex_stage: RTL and testbench
=================================

Name: shift_ex_stage

Overview:
- Two-stage pipelined shift/rotate execution unit for the 16-bit WISC datapath, between the ID/EX operand latch and the EX/MEM result latch.
- Accepts one shift/rotate micro-op per cycle under a valid/ready handshake and returns a registered 16-bit result plus zero flag two cycles later.
- Supports backpressure from downstream and a synchronous flush for branch mispredict squash.
- Implements all four ISA shift ops (ROL, SLL, ROR, SRL); ROL is computed as a rotate-right by the negated count.

Parameters:
- WIDTH, 16, datapath width; only 16 is supported.
- CNT_W, 4, shift-count width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents a micro-op.
- in_ready  output  1  stage can accept a micro-op this cycle.
- in_op  input  2  shift op: 00 ROL, 01 SLL, 10 ROR, 11 SRL.
- in_data  input  WIDTH  operand Rs.
- in_cnt  input  CNT_W  shift amount, 0..15.
- in_rd  input  3  destination register tag, carried through.
- flush  input  1  squash all in-flight micro-ops.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  shift/rotate result.
- out_zero  output  1  out_data == 0.
- out_rd  output  3  destination tag of the result.
- busy  output  1  s1_valid OR out_valid.

Behaviour:
- Reset: asynchronous on rst_n low, synchronous release. Clears s1_valid, out_valid, all data/tag/op registers to 0. out_zero resets to 0, not recomputed from data. in_ready is 1 one cycle after release.
- Pipeline: S1 register holds {op, data, cnt, rd}. S2 register holds {result, zero, rd}. Result is combinational from S1, registered into S2.
- Handshake:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = s1_valid & s2_adv.
  - in_ready = !s1_valid | s2_adv (combinational; no comb path from in_valid).
  - Accept when in_valid & in_ready. Transfer out when out_valid & out_ready.
- Latency: an op accepted at edge N reaches out_valid=1 after edge N+1, i.e. visible in cycle N+1..N+2 with no stall. Throughput is 1 op/cycle with out_ready held high.
- Stall:
  - When out_valid & !out_ready, S2 holds and out_data/out_zero/out_rd are stable.
  - If S1 is also full, in_ready=0 and S1 holds.
  - No op is dropped or duplicated.
- Simultaneous events at one edge: S2 unloads while S1 moves to S2 while a new op loads into S1. This is legal and required for full throughput.
- Arithmetic (cnt taken as unsigned):
  - ROR: result[i] = data[(i+cnt) mod 16].
  - ROL: ROR by (16-cnt) mod 16; cnt=0 gives identity.
  - SLL: data << cnt, zero-filled.
  - SRL: data >> cnt, logical, zero-filled.
  - cnt=0 gives data unchanged for all ops.
- Zero flag: out_zero = (result == 16'h0000), registered with result.
- Flush: synchronous, highest priority. At an edge with flush=1, s1_valid and out_valid clear and no op is accepted that cycle, even if in_valid&in_ready. in_ready is still driven normally during flush; the upstream must treat the op as squashed. Data registers may hold stale values; only valids are cleared.
- Reset mid-operation: in-flight ops are lost; no output until a new op is accepted.
- Invalid in_op: not possible, since all 2-bit encodings are defined.

Test Plan:
- Basic ops, out_ready=1:
  - ROR 0x1234 cnt 4 -> out_data 0x4123, zero 0.
  - ROL 0x8001 cnt 1 -> 0x0003.
  - SLL 0xFFFF cnt 15 -> 0x8000.
  - SRL 0x8000 cnt 15 -> 0x0001.
  - Each out_valid arrives exactly 2 edges after acceptance; out_rd matches in_rd.
- Count edge cases:
  - cnt 0 on all four ops with data 0xA5C3 -> 0xA5C3.
  - SRL 0x0001 cnt 1 -> 0x0000, out_zero 1.
  - ROL 0x0001 cnt 15 -> 0x8000.
- Back-to-back streaming: 8 consecutive ops, in_valid and out_ready held 1 -> 8 results on 8 consecutive cycles, in order; in_ready never drops.
- Backpressure: hold out_ready=0 for 4 cycles while issuing 3 ops.
  - in_ready drops after 2 accepts; out_data stays stable.
  - Releasing out_ready drains both ops in order, then the third is accepted.
- Flush: with S1 and S2 both valid and a new op presented, assert flush for 1 cycle.
  - Next cycle out_valid=0, busy=0.
  - The presented op never appears at the output.
- Async reset: assert rst_n=0 mid-cycle with S2 full.
  - out_valid falls immediately without waiting for a clock edge; all outputs read 0.
  - After release, ROR 0x0F00 cnt 8 -> 0x000F.

Source files
------------

// File: rtl/shift_ex_stage.sv
// Two-stage shift/rotate execution unit for the 16-bit WISC datapath.
// S1 latches the micro-op, S2 latches the registered result, zero flag and destination tag.
module shift_ex_stage #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [2:0]       in_rd,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic [2:0]       out_rd,
  output logic             busy
);

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } op_e;

  logic             s1_valid_q, s1_valid_d;
  op_e              s1_op_q;
  logic [WIDTH-1:0] s1_data_q;
  logic [CNT_W-1:0] s1_cnt_q;
  logic [2:0]       s1_rd_q;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q;
  logic             s2_zero_q;
  logic [2:0]       s2_rd_q;

  logic             s2_adv, s1_adv, accept;
  logic [CNT_W-1:0] rot_amt;
  logic [2*WIDTH-1:0] rot_wide;
  logic [WIDTH-1:0] result_d;

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_adv;
    in_ready = !s1_valid_q || s2_adv;
    accept   = in_valid && in_ready && !flush;
  end

  // Flush wins over every other update; only the valids are squashed.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (accept)      s1_valid_d = 1'b1;
      else if (s1_adv) s1_valid_d = 1'b0;
      if (s2_adv)      s2_valid_d = s1_valid_q;
    end
  end

  // ROL shares the rotate-right path using the two's-complement count.
  always_comb begin
    rot_amt  = (s1_op_q == OP_ROL) ? (~s1_cnt_q + CNT_W'(1)) : s1_cnt_q;
    rot_wide = {s1_data_q, s1_data_q} >> rot_amt;
    result_d = '0;
    unique case (s1_op_q)
      OP_ROL, OP_ROR: result_d = rot_wide[WIDTH-1:0];
      OP_SLL:         result_d = s1_data_q << s1_cnt_q;
      OP_SRL:         result_d = s1_data_q >> s1_cnt_q;
      default:        result_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_ROL;
      s1_data_q  <= '0;
      s1_cnt_q   <= '0;
      s1_rd_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_op_q   <= op_e'(in_op);
        s1_data_q <= in_data;
        s1_cnt_q  <= in_cnt;
        s1_rd_q   <= in_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_zero_q  <= 1'b0;
      s2_rd_q    <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s1_adv) begin
        s2_data_q <= result_d;
        s2_zero_q <= (result_d == '0);
        s2_rd_q   <= s1_rd_q;
      end
    end
  end

  always_comb begin
    out_valid = s2_valid_q;
    out_data  = s2_data_q;
    out_zero  = s2_zero_q;
    out_rd    = s2_rd_q;
    busy      = s1_valid_q || s2_valid_q;
  end

endmodule

// File: tb/tb_shift_ex_stage.sv
// Self-checking bench for shift_ex_stage: scoreboard of expected results from a
// bit-level shift/rotate model, checked every cycle, plus directed literal expectations.
module tb_shift_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = '0;
  logic [15:0] in_data = '0;
  logic [3:0]  in_cnt = '0;
  logic [2:0]  in_rd = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_zero;
  logic [2:0]  out_rd;
  logic        busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] d;
    logic        z;
    logic [2:0]  rd;
    logic [15:0] lit;
    bit          hl;
  } item_t;
  item_t exp_q[$];

  logic [15:0] tb_lit = '0;
  bit          tb_hl = 1'b0;
  int          run = 0;
  int          max_run = 0;
  int          ready_drops = 0;

  shift_ex_stage #(.WIDTH(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .in_cnt(in_cnt), .in_rd(in_rd),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .out_rd(out_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bitwise definition: ROR result[i] = data[(i+cnt) mod 16]; ROL = ROR by (16-cnt) mod 16.
  function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] d, input logic [3:0] c);
    logic [15:0] r;
    int unsigned n;
    r = '0;
    case (op)
      2'b01: r = d << c;
      2'b11: r = d >> c;
      default: begin
        n = (op == 2'b00) ? (16 - int'(c)) % 16 : int'(c);
        for (int i = 0; i < 16; i++) r[i] = d[(i + n) % 16];
      end
    endcase
    return r;
  endfunction

  // Compare process: scoreboard occupancy defines busy and in_ready; the head of the
  // scoreboard defines every visible output while out_valid is high.
  always @(negedge clk) begin
    item_t it;
    if (!rst_n) begin
      exp_q.delete();
      run = 0;
    end else begin
      chk("busy", busy, exp_q.size() != 0);
      chk("in_ready", in_ready, !(exp_q.size() >= 2 && !out_ready));
      if (in_valid && !in_ready) ready_drops++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 1'b0);
        end else begin
          chk("out_data", out_data, exp_q[0].d);
          chk("out_zero", out_zero, exp_q[0].z);
          chk("out_rd", out_rd, exp_q[0].rd);
          if (exp_q[0].hl) chk("out_data_literal", out_data, exp_q[0].lit);
        end
      end
      if (out_valid && out_ready) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (in_valid && in_ready) begin
          it.d   = model(in_op, in_data, in_cnt);
          it.z   = (it.d == 16'h0000);
          it.rd  = in_rd;
          it.lit = tb_lit;
          it.hl  = tb_hl;
          exp_q.push_back(it);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [15:0] d, input logic [3:0] c,
                      input logic [2:0] rd, input logic [15:0] lit, input bit hl);
    bit acc;
    bit done;
    done = 1'b0;
    in_op = op; in_data = d; in_cnt = c; in_rd = rd;
    tb_lit = lit; tb_hl = hl;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) done = 1'b1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    tb_hl = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 40 && !idle; k++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    if (!idle) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    chk("pin_ror", model(2'b10, 16'h1234, 4'd4), 16'h4123);
    chk("pin_rol", model(2'b00, 16'h8001, 4'd1), 16'h0003);
    chk("pin_rol15", model(2'b00, 16'h0001, 4'd15), 16'h8000);
    chk("pin_srl", model(2'b11, 16'h8000, 4'd15), 16'h0001);

    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_out_zero", out_zero, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", in_ready, 1'b1);

    // Basic ops with latency check on the first.
    out_ready = 1'b1;
    send(2'b10, 16'h1234, 4'd4, 3'd5, 16'h4123, 1'b1);
    @(negedge clk);
    chk("latency_edge1_invalid", out_valid, 1'b0);
    @(negedge clk);
    chk("latency_edge2_valid", out_valid, 1'b1);
    chk("latency_rd", out_rd, 3'd5);
    chk("latency_zero", out_zero, 1'b0);
    @(posedge clk); #1;
    send(2'b00, 16'h8001, 4'd1, 3'd1, 16'h0003, 1'b1);
    send(2'b01, 16'hFFFF, 4'd15, 3'd2, 16'h8000, 1'b1);
    send(2'b11, 16'h8000, 4'd15, 3'd3, 16'h0001, 1'b1);
    wait_idle();

    // Count edge cases.
    for (int op = 0; op < 4; op++) send(2'(op), 16'hA5C3, 4'd0, 3'(op), 16'hA5C3, 1'b1);
    send(2'b11, 16'h0001, 4'd1, 3'd6, 16'h0000, 1'b1);
    @(negedge clk); @(negedge clk);
    chk("srl_zero_flag", out_zero, 1'b1);
    @(posedge clk); #1;
    send(2'b00, 16'h0001, 4'd15, 3'd7, 16'h8000, 1'b1);
    wait_idle();

    // Back-to-back streaming.
    max_run = 0;
    ready_drops = 0;
    for (int i = 0; i < 8; i++)
      send(2'(i), 16'h1357 + 16'(i * 16'h1111), 4'(i * 3), 3'(i), 16'h0000, 1'b0);
    wait_idle();
    chk("stream_consecutive", max_run, 32'd8);
    chk("stream_ready_drops", ready_drops, 32'd0);

    // Backpressure.
    out_ready = 1'b0;
    send(2'b10, 16'h00F0, 4'd4, 3'd1, 16'h000F, 1'b1);
    send(2'b01, 16'h0101, 4'd8, 3'd2, 16'h0100, 1'b1);
    chk("bp_ready_low", in_ready, 1'b0);
    fork
      send(2'b11, 16'hF000, 4'd12, 3'd3, 16'h000F, 1'b1);
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_idle();

    // Flush with both stages full and a new op presented.
    out_ready = 1'b0;
    send(2'b10, 16'h1111, 4'd1, 3'd1, 16'h0000, 1'b0);
    send(2'b10, 16'h2222, 4'd2, 3'd2, 16'h0000, 1'b0);
    in_op = 2'b01; in_data = 16'hDEAD; in_cnt = 4'd1; in_rd = 3'd4;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_busy", busy, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    // Asynchronous reset with S2 full.
    out_ready = 1'b0;
    send(2'b10, 16'h4321, 4'd4, 3'd5, 16'h1432, 1'b1);
    @(posedge clk); #3;
    chk("pre_reset_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_out_data", out_data, 16'h0000);
    chk("async_out_zero", out_zero, 1'b0);
    chk("async_out_rd", out_rd, 3'd0);
    chk("async_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(2'b10, 16'h0F00, 4'd8, 3'd2, 16'h000F, 1'b1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
